// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the FP add/sub datapath.
// Widths of the post-add normalization path, the all-zero LZC code,
// the lane tag type and the packed normalization result.
package fp_addsub_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 26;  // includes carry and guard bits
  localparam int LZ_W    = 5;
  localparam int LZ_ZERO = 26;  // LZC code for an all-zero mantissa

  typedef logic lane_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [LZ_W-1:0]   lz;
    logic              zero;
    logic              uflow;
  } norm_res_t;

endpackage

// File: rtl/fp_lzc26.sv
// 26-bit leading-zero counter (combinational).
// Ports:
//   mant : mantissa to scan, bit 25 is the MSB
//   lz   : zeros above the first 1 (0..25), or 26 when mant is all zero
module fp_lzc26
  import fp_addsub_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [LZ_W-1:0]   lz
);

  // Scan LSB to MSB so the highest set bit is the last to write lz.
  always_comb begin
    lz = LZ_W'(LZ_ZERO);
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) lz = LZ_W'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_scheduler.sv
// Shared post-add normalization unit for two FP add/sub lanes.
// Round-robin arbitrates two valid/ready request lanes into a 2-stage
// pipeline: S1 holds the granted request, S2 (the out_* registers) holds
// the normalized mantissa, adjusted exponent, applied shift and flags.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   reqN_valid/ready/mant/exp  : lane N request handshake and operands
//   out_valid/ready            : result handshake to the rounding stage
//   out_lane                   : originating lane of the result
//   out_mant/exp/lz            : normalized mantissa, exponent, shift used
//   out_zero/uflow             : all-zero input / shift clamped by exponent
module fp_norm_scheduler #(
  parameter int EXP_W  = fp_addsub_pkg::EXP_W,
  parameter int MANT_W = fp_addsub_pkg::MANT_W,
  parameter int LZ_W   = fp_addsub_pkg::LZ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [MANT_W-1:0] req0_mant,
  input  logic [EXP_W-1:0]  req0_exp,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [MANT_W-1:0] req1_mant,
  input  logic [EXP_W-1:0]  req1_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_lane,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [LZ_W-1:0]   out_lz,
  output logic              out_zero,
  output logic              out_uflow
);
  import fp_addsub_pkg::LZ_ZERO;
  import fp_addsub_pkg::lane_t;
  import fp_addsub_pkg::norm_res_t;

  logic              s1_valid;
  lane_t             s1_lane;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic              rr_ptr;

  logic              s1_en, s2_en, any_req, take;
  lane_t             grant;
  logic [LZ_W-1:0]   lz, shamt;
  logic              zero, uflow;
  norm_res_t         res;

  // Stall chain: S1 may load whenever its content moves on (or it is empty),
  // so accept and drain in the same cycle keep full rate.
  assign s2_en   = !out_valid || out_ready;
  assign s1_en   = !s1_valid || s2_en;

  // Round robin only matters on contention; a lone requester always wins.
  assign any_req = req0_valid || req1_valid;
  assign grant   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  assign take    = s1_en && any_req && !rst;

  assign req0_ready = take && (grant == 1'b0);
  assign req1_ready = take && (grant == 1'b1);

  fp_lzc26 u_lzc (
    .mant (s1_mant),
    .lz   (lz)
  );

  // Normalize: shift out leading zeros, but never drive the exponent below
  // zero -- if the zeros reach the exponent, shift by the exponent instead.
  // lz <= 25 bounds exp in the underflow case, so its low bits are the shift.
  // An all-zero mantissa shifted by 26 stays zero and reports lz = 26.
  always_comb begin
    zero      = (lz == LZ_W'(LZ_ZERO));
    uflow     = !zero && (EXP_W'(lz) >= s1_exp);
    shamt     = uflow ? s1_exp[LZ_W-1:0] : lz;
    res.mant  = s1_mant << shamt;
    res.exp   = (zero || uflow) ? '0 : s1_exp - EXP_W'(lz);
    res.lz    = shamt;
    res.zero  = zero;
    res.uflow = uflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lane   <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      rr_ptr    <= 1'b0;
      out_valid <= 1'b0;
      out_lane  <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_lz    <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= take;
        if (take) begin
          s1_lane <= grant;
          s1_mant <= grant ? req1_mant : req0_mant;
          s1_exp  <= grant ? req1_exp : req0_exp;
          rr_ptr  <= ~grant;
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_lane  <= s1_lane;
          out_mant  <= res.mant;
          out_exp   <= res.exp;
          out_lz    <= res.lz;
          out_zero  <= res.zero;
          out_uflow <= res.uflow;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_scheduler.sv
// Scoreboard bench for fp_norm_scheduler: accepted requests are turned into
// expected results by a behavioural normalizer; a negedge monitor pops and
// compares every delivered result, checks arbitration fairness and output
// stability under backpressure.
module tb_fp_norm_scheduler;

  typedef struct {
    logic        lane;
    logic [25:0] mant;
    logic [7:0]  exp;
    logic [4:0]  lz;
    logic        zero;
    logic        uflow;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, out_ready;
  logic        req0_ready, req1_ready;
  logic [25:0] req0_mant, req1_mant;
  logic [7:0]  req0_exp, req1_exp;
  logic        out_valid, out_lane, out_zero, out_uflow;
  logic [25:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_lz;

  int   tests = 0;
  int   fails = 0;
  int   pop_cnt = 0;
  exp_t sb[$];
  logic grant_log[$];
  logic model_ptr = 1'b0;
  bit   hs0 = 0, hs1 = 0, stall_prev = 0;
  logic [42:0] snap;

  fp_norm_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_mant(req0_mant), .req0_exp(req0_exp),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_mant(req1_mant), .req1_exp(req1_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_mant(out_mant), .out_exp(out_exp), .out_lz(out_lz),
    .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  // Reference: count zeros below the MSB one bit at a time, then clamp the
  // shift so the exponent cannot go below zero.
  function automatic exp_t model(input logic lane, input logic [25:0] m, input logic [7:0] e);
    exp_t r;
    int   lz, sh;
    r.lane = lane;
    if (m == 26'd0) begin
      r.mant = 0; r.exp = 0; r.lz = 5'd26; r.zero = 1; r.uflow = 0;
    end else begin
      lz = 0;
      while (m[25-lz] == 1'b0) lz++;
      if (lz < int'(e)) begin
        sh = lz; r.exp = 8'(int'(e) - lz); r.uflow = 0;
      end else begin
        sh = int'(e); r.exp = 0; r.uflow = 1;
      end
      r.mant = m << sh;
      r.lz   = 5'(sh);
      r.zero = 0;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic gen(output logic [25:0] m, output logic [7:0] e);
    if ($urandom_range(0, 5) == 0) m = 26'd0;
    else m = 26'($urandom()) >> $urandom_range(0, 25);
    if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 30));
    else e = 8'($urandom_range(0, 255));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t x;
    logic lane;
    if (rst) begin
      sb.delete();
      model_ptr = 1'b0; hs0 = 0; hs1 = 0; stall_prev = 0;
      chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    end else begin
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      chk("one_ready", 64'(req0_ready && req1_ready), 64'd0);
      if (hs0 || hs1) begin
        lane = hs1;
        if (req0_valid && req1_valid) chk("rr_lane", 64'(lane), 64'(model_ptr));
        model_ptr = !lane;
        grant_log.push_back(lane);
        sb.push_back(lane ? model(1'b1, req1_mant, req1_exp) : model(1'b0, req0_mant, req0_exp));
      end
      if (stall_prev)
        chk("hold", 64'({out_valid, out_lane, out_mant, out_exp, out_lz, out_zero, out_uflow}), 64'(snap));
      stall_prev = out_valid && !out_ready;
      snap = {out_valid, out_lane, out_mant, out_exp, out_lz, out_zero, out_uflow};
      if (out_valid && out_ready) begin
        tests++;
        pop_cnt++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL result: got unexpected lane=%0d mant=%h, expected nothing", out_lane, out_mant);
        end else begin
          x = sb.pop_front();
          if (out_lane !== x.lane || out_mant !== x.mant || out_exp !== x.exp ||
              out_lz !== x.lz || out_zero !== x.zero || out_uflow !== x.uflow) begin
            fails++;
            $display("FAIL result: got lane=%0d mant=%h exp=%0d lz=%0d z=%0d u=%0d expected lane=%0d mant=%h exp=%0d lz=%0d z=%0d u=%0d",
                     out_lane, out_mant, out_exp, out_lz, out_zero, out_uflow,
                     x.lane, x.mant, x.exp, x.lz, x.zero, x.uflow);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req0_valid = 0; req1_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Holds each request until its handshake, then lets the pipe empty.
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((req0_valid || req1_valid || sb.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk); @(posedge clk); #1;
      if (hs0) req0_valid = 0;
      if (hs1) req1_valid = 0;
      n++;
    end
    chk("drain_done", 64'({req0_valid, req1_valid, out_valid, sb.size() != 0}), 64'd0);
  endtask

  task automatic one_shot(input logic lane, input logic [25:0] m, input logic [7:0] e,
                          input logic [25:0] xm, input logic [7:0] xe, input logic [4:0] xlz,
                          input logic xz, input logic xu);
    @(posedge clk); #1;
    out_ready = 1;
    if (lane) begin req1_valid = 1; req1_mant = m; req1_exp = e; end
    else begin req0_valid = 1; req0_mant = m; req0_exp = e; end
    @(negedge clk);
    chk("os_ready", 64'(lane ? req1_ready : req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("os_lat1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("os_valid", 64'(out_valid), 64'd1);
    chk("os_result", 64'({out_lane, out_mant, out_exp, out_lz, out_zero, out_uflow}),
        64'({lane, xm, xe, xlz, xz, xu}));
  endtask

  initial begin
    int acc, base, n;
    rst = 1; out_ready = 0;
    req0_valid = 0; req1_valid = 0;
    req0_mant = 0; req1_mant = 0; req0_exp = 0; req1_exp = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_state", 64'({out_valid, out_lane, out_mant, out_exp, out_lz, out_zero, out_uflow}), 64'd0);
    @(posedge clk); #1 rst = 0;

    // Directed single-lane cases
    one_shot(1'b0, 26'h0010000, 8'd100, 26'h2000000, 8'd91, 5'd9, 1'b0, 1'b0);
    one_shot(1'b1, 26'h0000000, 8'd50, 26'h0000000, 8'd0, 5'd26, 1'b1, 1'b0);
    one_shot(1'b0, 26'h0000100, 8'd5, 26'h0002000, 8'd0, 5'd5, 1'b0, 1'b1);
    drain();

    // Both lanes continuously valid: grants alternate from lane 0
    do_reset();
    grant_log.delete();
    @(posedge clk); #1;
    out_ready = 1; req0_valid = 1; req1_valid = 1;
    gen(req0_mant, req0_exp); gen(req1_mant, req1_exp);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); @(posedge clk); #1;
      if (hs0) begin if (i == 5) req0_valid = 0; else gen(req0_mant, req0_exp); end
      if (hs1) begin if (i == 5) req1_valid = 0; else gen(req1_mant, req1_exp); end
    end
    drain();
    chk("alt_count", 64'(grant_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("alt_grant", 64'(grant_log[i]), 64'(i % 2));

    // Backpressure: 4 requests from lane 0, output held for 3 cycles
    do_reset();
    base = pop_cnt;
    @(posedge clk); #1;
    out_ready = 0; req0_valid = 1; gen(req0_mant, req0_exp);
    @(negedge clk); chk("bp_acc0", 64'(req0_ready), 64'd1);
    @(posedge clk); #1; gen(req0_mant, req0_exp);
    @(negedge clk); chk("bp_acc1", 64'(req0_ready), 64'd1);
    @(posedge clk); #1; gen(req0_mant, req0_exp);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
      chk("bp_outv", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    acc = 2; n = 0;
    while (acc < 4 && n < 20) begin
      @(negedge clk); @(posedge clk); #1;
      if (hs0) begin acc++; if (acc < 4) gen(req0_mant, req0_exp); else req0_valid = 0; end
      n++;
    end
    drain();
    chk("bp_count", 64'(pop_cnt - base), 64'd4);

    // Reset with S1 and S2 full
    do_reset();
    @(posedge clk); #1;
    out_ready = 0; req0_valid = 1; req1_valid = 1;
    gen(req0_mant, req0_exp); gen(req1_mant, req1_exp);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); @(posedge clk); #1;
      if (hs0) gen(req0_mant, req0_exp);
      if (hs1) gen(req1_mant, req1_exp);
    end
    @(negedge clk);
    chk("rm_full", 64'({out_valid, req0_ready, req1_ready}), 64'b100);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("rm_flush", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    gen(req0_mant, req0_exp); gen(req1_mant, req1_exp);
    @(negedge clk);
    chk("rm_ptr", 64'({req1_ready, req0_ready}), 64'b01);
    @(posedge clk); #1 req0_valid = 0;
    drain();
    one_shot(1'b1, 26'h0000001, 8'd30, 26'h2000000, 8'd5, 5'd25, 1'b0, 1'b0);
    drain();

    // Randomized traffic with random backpressure
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        if (req0_valid) gen(req0_mant, req0_exp);
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        if (req1_valid) gen(req1_mant, req1_exp);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (hs0) req0_valid = 0;
    if (hs1) req1_valid = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_norm_scheduler.md
Name: fp_norm_scheduler

Overview:
Shares one post-add normalization unit between two FP add/sub lanes. The unit is a 26-bit leading-nought counter, a left shifter and an exponent adjust. The block round-robin arbitrates lane requests with valid/ready handshakes and runs them through a 2-stage pipeline. It returns each result with its lane tag. It sits between the mantissa add stage and the rounding stage of the pipelined adders.

Parameters:
EXP_W, 8, exponent width (single precision)
MANT_W, 26, mantissa width incl. carry/guard; fixed at 26 (LZC is 26-bit)
LZ_W, 5, leading-nought count width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  lane 0 request valid
req0_ready  out  1  lane 0 request accepted this cycle
req0_mant  in  MANT_W  lane 0 unnormalized mantissa
req0_exp  in  EXP_W  lane 0 exponent
req1_valid  in  1  lane 1 request valid
req1_ready  out  1  lane 1 request accepted this cycle
req1_mant  in  MANT_W  lane 1 unnormalized mantissa
req1_exp  in  EXP_W  lane 1 exponent
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_lane  out  1  originating lane
out_mant  out  MANT_W  normalized mantissa (MSB set unless zero/underflow)
out_exp  out  EXP_W  adjusted exponent
out_lz  out  LZ_W  leading-nought count applied
out_zero  out  1  input mantissa was all zero
out_uflow  out  1  required shift exceeded exponent

Behaviour:
- Reset: all *_ready=0 during rst; out_valid=0; out_lane, out_mant, out_exp, out_lz, out_zero, out_uflow=0; stage-1 valid=0; RR pointer=0 (lane 0 favoured first).
- Pipeline: S1 registers the granted request (mant, exp, lane). S2 registers the normalized result onto out_*. Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Stall rule: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en. When stalled, the output holds all fields stable. There are no bubbles while out_ready=1.
- Arbitration: only when s1_en. If only one lane is valid, grant it. If both are valid, grant the lane equal to the RR pointer. After any grant the pointer becomes the other lane. Without a grant the pointer holds.
- reqN_ready = s1_en && grant==N && !rst. At most one ready is high per cycle.
- A requester must hold valid/data until ready. The block never drops or duplicates a request.
- LZC semantics: lz is the number of zeros from bit 25 down to the first 1. The full range is 0..25, and 26 means all-zero. Every position maps exactly, e.g. the first 1 at bit 16 gives 9.
- Normal case (mant!=0, lz < exp): out_mant = mant << lz; out_exp = exp - lz; out_lz = lz.
- Underflow (mant!=0, lz >= exp): shift only by exp, so out_mant = mant << exp; out_exp=0; out_lz=exp; out_uflow=1. Applies for exp < 26.
- Zero (mant==0): out_mant=0, out_exp=0, out_lz=26, out_zero=1, out_uflow=0.
- Exponent arithmetic is unsigned EXP_W; the subtract never wraps by construction.
- Reset mid-operation: rst flushes S1 and S2; in-flight requests are discarded. Requesters re-present after reset.
- Simultaneous accept at S1 and drain at S2 in the same cycle is legal and must sustain full rate.

Decomposition:
- Shared package fp_addsub_pkg: MANT_W=26, LZ_W=5, LZ_ZERO=26, lane-tag type (1 bit), normalize result struct {mant, exp, lz, zero, uflow}.
- Sub-module fp_lzc26: combinational 26-bit leading-nought counter, output 0..26. Instantiated once in S2; unit-tested standalone over all 27 single-hot/zero patterns.
- Arbiter, shifter, exponent adjust and pipeline registers stay in the top.

Test Plan:
- Single lane 0: mant=26'h0010000 (bit 16), exp=100, out_ready=1 -> 2 cycles later out_valid=1, lane=0, lz=9, out_mant=26'h2000000, out_exp=91.
- Both lanes valid continuously for 6 cycles, out_ready=1 -> grants alternate 0,1,0,1,0,1; outputs are in the same order with correct lanes; each ready is high every other cycle.
- Zero input: lane 1 mant=0, exp=50 -> out_zero=1, out_lz=26, out_mant=0, out_exp=0, out_uflow=0.
- Underflow: mant=26'h0000100 (lz=17), exp=5 -> out_uflow=1, out_exp=0, out_lz=5, out_mant=26'h0002000.
- Backpressure: stream 4 requests, hold out_ready=0 for 3 cycles -> out fields stable, S1 fills, both reqN_ready=0. On release, results drain in order with none lost or duplicated.
- Reset mid-stream: assert rst with S1 and S2 full -> next cycle out_valid=0, readies=0, pointer=0. A post-reset request from lane 1 completes normally.
